mtm_alu_packet_rx: RTL and testbench
====================================

# mtm_alu_packet_rx

Parametrised serial packet receiver for the MTM ALU: the next-generation replacement for the fixed-width deserializer feeding `mtm_Alu_core`.
- Samples the `sin` line at a configurable number of clocks per bit.
- Assembles framed bytes into two operands of configurable width plus a control byte.
- Checks framing, data-frame count and CRC-4.
- Presents either a validated packet or an error code to the core.

## Interface
- WORD_BYTES, 4: bytes per operand; operand width W = 8*WORD_BYTES.
- BIT_CLKS, 1: clock cycles per serial bit; must be ≥1.
- CRC_EN, 1: 1 enables CRC check; 0 accepts any CRC field.

Ports:
- clk  in  1  posedge clock.
- rst  in  1  one clock; reset is synchronous and active-high.
- sin  in  1  serial input; idles high.
- a  out  W  operand A of last good packet.
- b  out  W  operand B of last good packet.
- op  out  3  opcode of last good packet.
- pkt_valid  out  1  one-cycle pulse: a/b/op updated.
- err_valid  out  1  one-cycle pulse: packet rejected.
- err_code  out  2  01 = data/framing error, 10 = CRC error; held until next err_valid.

## Operation
- **Frame format:** 11 bits, in order:
  - start bit 0;
  - flag bit (0 = data frame, 1 = ctl frame);
  - d7..d0, MSB first;
  - stop bit 1.
- **Bit FSM states:** IDLE, START, BITS, STOP.
  - **IDLE:** when `sin`=0 is sampled, load the bit counter and go to START.
  - **START:** re-sample `sin` after floor(BIT_CLKS/2) clocks. This is the same cycle when BIT_CLKS=1. If `sin`=1, treat it as a glitch and return to IDLE with no error. If `sin`=0, go to BITS.
  - **BITS:** sample the flag bit and the 8 data bits, one every BIT_CLKS clocks.
  - **STOP:** sample the stop bit BIT_CLKS clocks later. Stop=0 is a framing error: err 01, the packet is discarded, the byte counter clears, and the FSM goes to IDLE.
- **Packet:** 2*WORD_BYTES data frames then one ctl frame.
  - The first WORD_BYTES data bytes form B, most-significant byte first.
  - The next WORD_BYTES data bytes form A, in the same byte order.
  - Ctl byte = {x, op[2:0], crc[3:0]}. Bit 7 is ignored.
- **Byte counter:** counts 0..2*WORD_BYTES.
  - Data frame arriving when the count is already 2*WORD_BYTES: err 01, the frame is discarded, and the counter clears to 0.
- **Ctl frame checks,** in this priority order:
  1. count ≠ 2*WORD_BYTES → err 01.
  2. CRC_EN and CRC mismatch → err 10.
  3. Otherwise → update a/b/op and pulse pkt_valid.
- After any ctl frame, the counter clears to 0.
- **CRC-4:** polynomial x^4+x+1, initial value 0000.
  - Computed MSB-first over {B, A, 1'b1, op}, which is 16*WORD_BYTES+4 bits.
  - Update per bit: fb = crc[3]^bit; crc = {crc[2:0],0} ^ (fb ? 4'b0011 : 0).
  - May be computed serially as bytes arrive or combinationally at the ctl frame.
- a/b/op change only on pkt_valid. A rejected packet leaves them unchanged.
- pkt_valid and err_valid are never high in the same cycle.

## Timing
- **Reset:** while rst=1 at a posedge:
  - a, b, op, pkt_valid, err_valid and err_code are all 0;
  - FSM goes to IDLE and the byte counter to 0;
  - any partial frame or packet is discarded.
  - Reset mid-frame behaves identically.
- **Frame length:** 11*BIT_CLKS clocks from start detection.
- **Output latency:** pkt_valid or err_valid is asserted on the clock after the cycle in which the stop bit (or the offending stop/flag decision) is sampled.
- **Back-to-back frames:** a new start bit may be detected on the cycle immediately after the stop-bit sample. Zero extra idle is required.
- With BIT_CLKS=1 and WORD_BYTES=4, a full packet is 9 frames = 99 clocks. pkt_valid is asserted at clock 100 after the first start bit.
- `sin` is sampled directly, with no synchroniser inside the block. Synchronisation is done at chip level.

## Test plan
1. **Good packet:** WORD_BYTES=4, BIT_CLKS=1. Send B=0x00000002, A=0x00000003, ctl=0x0A (op=000, crc=1010) → one pkt_valid pulse one clock after the ctl stop bit; a=0x3, b=0x2, op=0; err_valid stays 0.
2. **CRC error:** same as 1 but ctl=0x0B → err_valid pulse, err_code=10; pkt_valid stays 0; a/b/op keep their prior values.
3. **Short packet:** 7 data frames then ctl 0x0A → err_valid, err_code=01. An immediately following correct packet gives pkt_valid.
4. **Bad stop bit:** stop bit=0 in data frame 3 → err 01 one clock after that stop sample. Then a full good packet → pkt_valid with correct a/b.
5. **Oversampled line:** BIT_CLKS=4. A 1-clock low glitch on idle `sin` produces no error and no frame. The packet from 1 at 4 clocks/bit → pkt_valid with identical values.
6. **Reset mid-frame:** assert rst for 1 clock during the 5th data frame → all outputs 0 on the next cycle. A subsequent good packet is accepted normally.

Source files
------------

// File: rtl/mtm_alu_packet_rx.sv
// Serial packet receiver for the MTM ALU core: deserialises framed bytes into
// operands B and A plus an opcode, checks framing, frame count and CRC-4.
module mtm_alu_packet_rx #(
    parameter int WORD_BYTES = 4,
    parameter int BIT_CLKS   = 1,
    parameter int CRC_EN     = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sin,
    output logic [8*WORD_BYTES-1:0]   a,
    output logic [8*WORD_BYTES-1:0]   b,
    output logic [2:0]                op,
    output logic                      pkt_valid,
    output logic                      err_valid,
    output logic [1:0]                err_code
);

    localparam int W      = 8 * WORD_BYTES;
    localparam int NBYTES = 2 * WORD_BYTES;
    localparam int HALF   = BIT_CLKS / 2;
    localparam int CW     = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
    localparam int BCW    = $clog2(NBYTES + 1);

    localparam logic [CW-1:0]  TICK_LOAD = CW'(BIT_CLKS - 1);
    localparam logic [CW-1:0]  HALF_LOAD = CW'((HALF > 0) ? HALF - 1 : 0);
    localparam logic [BCW-1:0] FULL      = BCW'(NBYTES);

    typedef enum logic [1:0] {IDLE, START, BITS, STOP} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   tick_cnt, tick_cnt_nxt;
    logic [3:0]      bit_idx, bit_idx_nxt;
    logic [8:0]      shreg, shreg_nxt;
    logic            stop_bit, stop_bit_nxt;
    logic            frame_done, frame_done_nxt;

    logic [BCW-1:0]  byte_cnt;
    logic [2*W-1:0]  operands;
    logic [3:0]      crc_calc;

    // CRC-4 over x^4+x+1, MSB first, starting from zero.
    function automatic logic [3:0] crc4(input logic [2*W+3:0] msg);
        logic [3:0] c;
        logic       fb;
        c = 4'b0000;
        for (int i = 2*W+3; i >= 0; i--) begin
            fb = c[3] ^ msg[i];
            c  = {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
        end
        return c;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            stop_bit   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            tick_cnt   <= tick_cnt_nxt;
            bit_idx    <= bit_idx_nxt;
            shreg      <= shreg_nxt;
            stop_bit   <= stop_bit_nxt;
            frame_done <= frame_done_nxt;
        end
    end

    // Bit-level FSM: with one clock per bit the start bit is confirmed by the
    // very sample that detected it, so START is skipped.
    always_comb begin
        state_nxt      = state;
        tick_cnt_nxt   = tick_cnt;
        bit_idx_nxt    = bit_idx;
        shreg_nxt      = shreg;
        stop_bit_nxt   = stop_bit;
        frame_done_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (!sin) begin
                    if (HALF == 0) begin
                        state_nxt    = BITS;
                        tick_cnt_nxt = TICK_LOAD;
                        bit_idx_nxt  = '0;
                    end else begin
                        state_nxt    = START;
                        tick_cnt_nxt = HALF_LOAD;
                    end
                end
            end
            START: begin
                if (tick_cnt != '0) begin
                    tick_cnt_nxt = tick_cnt - 1'b1;
                end else if (sin) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt    = BITS;
                    tick_cnt_nxt = TICK_LOAD;
                    bit_idx_nxt  = '0;
                end
            end
            BITS: begin
                if (tick_cnt != '0) begin
                    tick_cnt_nxt = tick_cnt - 1'b1;
                end else begin
                    shreg_nxt    = {shreg[7:0], sin};
                    tick_cnt_nxt = TICK_LOAD;
                    if (bit_idx == 4'd8) begin
                        state_nxt = STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick_cnt != '0) begin
                    tick_cnt_nxt = tick_cnt - 1'b1;
                end else begin
                    stop_bit_nxt   = sin;
                    frame_done_nxt = 1'b1;
                    state_nxt      = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign crc_calc = crc4({operands, 1'b1, shreg[6:4]});

    // Packet assembly runs one clock behind the stop sample; shreg is stable
    // here because the next frame cannot sample its flag bit yet.
    always_ff @(posedge clk) begin
        if (rst) begin
            a         <= '0;
            b         <= '0;
            op        <= '0;
            pkt_valid <= 1'b0;
            err_valid <= 1'b0;
            err_code  <= 2'b00;
            byte_cnt  <= '0;
            operands  <= '0;
        end else begin
            pkt_valid <= 1'b0;
            err_valid <= 1'b0;
            if (frame_done) begin
                if (!stop_bit) begin
                    err_valid <= 1'b1;
                    err_code  <= 2'b01;
                    byte_cnt  <= '0;
                end else if (!shreg[8]) begin
                    if (byte_cnt == FULL) begin
                        err_valid <= 1'b1;
                        err_code  <= 2'b01;
                        byte_cnt  <= '0;
                    end else begin
                        operands <= {operands[2*W-9:0], shreg[7:0]};
                        byte_cnt <= byte_cnt + 1'b1;
                    end
                end else begin
                    byte_cnt <= '0;
                    if (byte_cnt != FULL) begin
                        err_valid <= 1'b1;
                        err_code  <= 2'b01;
                    end else if ((CRC_EN != 0) && (crc_calc != shreg[3:0])) begin
                        err_valid <= 1'b1;
                        err_code  <= 2'b10;
                    end else begin
                        b         <= operands[2*W-1:W];
                        a         <= operands[W-1:0];
                        op        <= shreg[6:4];
                        pkt_valid <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mtm_alu_packet_rx.sv
// Bench for mtm_alu_packet_rx: one instance at 1 clock/bit, one at 4 clocks/bit,
// both compared every cycle against a packet-level model with an event queue.
module tb_mtm_alu_packet_rx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        sin0, sin1;
    logic [31:0] a0, b0, a1, b1;
    logic [2:0]  op0, op1;
    logic        pv0, pv1, ev0, ev1;
    logic [1:0]  ec0, ec1;

    mtm_alu_packet_rx #(.WORD_BYTES(4), .BIT_CLKS(1), .CRC_EN(1)) dut_fast (
        .clk(clk), .rst(rst), .sin(sin0), .a(a0), .b(b0), .op(op0),
        .pkt_valid(pv0), .err_valid(ev0), .err_code(ec0)
    );

    mtm_alu_packet_rx #(.WORD_BYTES(4), .BIT_CLKS(4), .CRC_EN(1)) dut_slow (
        .clk(clk), .rst(rst), .sin(sin1), .a(a1), .b(b1), .op(op1),
        .pkt_valid(pv1), .err_valid(ev1), .err_code(ec1)
    );

    typedef struct {
        int          cyc;
        int          inst;
        bit          is_pkt;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [1:0]  code;
    } ev_t;

    ev_t         evq[$];
    logic [7:0]  m_bytes[$];
    logic [31:0] m_a[2], m_b[2];
    logic [2:0]  m_op[2];
    logic [1:0]  m_code[2];

    int cyc = 0;
    int act = 0;
    bit checking = 1'b0;
    int n_cmp = 0;
    int n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Remainder of M(x)*x^4 divided by x^4+x+1, by long division.
    function automatic logic [3:0] crc_ref(input logic [31:0] bv, input logic [31:0] av, input logic [2:0] o);
        logic [71:0] v;
        v = {bv, av, 1'b1, o, 4'b0000};
        for (int i = 71; i >= 4; i--)
            if (v[i]) v[i -: 5] = v[i -: 5] ^ 5'b10011;
        return v[3:0];
    endfunction

    function automatic void clear_model();
        for (int i = 0; i < 2; i++) begin
            m_a[i] = '0; m_b[i] = '0; m_op[i] = '0; m_code[i] = '0;
        end
        evq.delete();
        m_bytes.delete();
    endfunction

    // Packet rules applied to one received frame; pc is the cycle its result appears.
    task automatic model_frame(input bit flag, input logic [7:0] d, input bit stop_ok, input int pc);
        ev_t e;
        logic [31:0] bb, aa;
        e.cyc = pc; e.inst = act; e.is_pkt = 1'b0;
        e.a = '0; e.b = '0; e.op = '0; e.code = 2'b01;
        if (!stop_ok) begin
            m_bytes.delete();
            evq.push_back(e);
        end else if (!flag) begin
            if (m_bytes.size() == 8) begin
                m_bytes.delete();
                evq.push_back(e);
            end else begin
                m_bytes.push_back(d);
            end
        end else begin
            if (m_bytes.size() != 8) begin
                evq.push_back(e);
            end else begin
                bb = '0; aa = '0;
                for (int k = 0; k < 4; k++) bb = {bb[23:0], m_bytes[k]};
                for (int k = 4; k < 8; k++) aa = {aa[23:0], m_bytes[k]};
                if (crc_ref(bb, aa, d[6:4]) != d[3:0]) begin
                    e.code = 2'b10;
                end else begin
                    e.is_pkt = 1'b1; e.a = aa; e.b = bb; e.op = d[6:4];
                end
                evq.push_back(e);
            end
            m_bytes.delete();
        end
    endtask

    always @(negedge clk) begin
        ev_t         e;
        bit          hit;
        logic        exp_pv, exp_ev;
        string       pfx;
        if (checking) begin
            for (int i = 0; i < 2; i++) begin
                pfx = (i != 0) ? "slow" : "fast";
                exp_pv = 1'b0; exp_ev = 1'b0;
                hit = (evq.size() > 0) && (evq[0].inst == i) && (evq[0].cyc == cyc);
                if (hit) begin
                    e = evq.pop_front();
                    if (e.is_pkt) begin
                        exp_pv = 1'b1;
                        m_a[i] = e.a; m_b[i] = e.b; m_op[i] = e.op;
                    end else begin
                        exp_ev = 1'b1;
                        m_code[i] = e.code;
                    end
                end
                checkOutput({pfx, ".pkt_valid"}, (i != 0) ? pv1 : pv0, exp_pv);
                checkOutput({pfx, ".err_valid"}, (i != 0) ? ev1 : ev0, exp_ev);
                checkOutput({pfx, ".a"},  (i != 0) ? a1 : a0, m_a[i]);
                checkOutput({pfx, ".b"},  (i != 0) ? b1 : b0, m_b[i]);
                checkOutput({pfx, ".op"}, (i != 0) ? op1 : op0, m_op[i]);
                checkOutput({pfx, ".err_code"}, (i != 0) ? ec1 : ec0, m_code[i]);
            end
        end
    end

    task automatic drive(input logic v);
        if (act != 0) sin1 = v; else sin0 = v;
    endtask

    task automatic idle(input int n);
        drive(1'b1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Sends one 11-bit frame starting right now (caller sits just after a posedge).
    task automatic applyStimulus(input bit flag, input logic [7:0] d, input bit stop_ok);
        int bc, s;
        logic [10:0] fr;
        bc = (act != 0) ? 4 : 1;
        fr = {1'b0, flag, d, stop_ok};
        s  = cyc + 1;
        model_frame(flag, d, stop_ok, s + bc/2 + 10*bc + 1);
        for (int i = 10; i >= 0; i--) begin
            drive(fr[i]);
            repeat (bc) begin @(posedge clk); #1; end
        end
    endtask

    task automatic send_packet(input logic [31:0] bv, input logic [31:0] av, input logic [2:0] o,
                               input bit crc_good, input int ndata, input int bad_stop, input int gap);
        logic [63:0] ba;
        logic [3:0]  crc;
        logic [7:0]  byt;
        ba  = {bv, av};
        crc = crc_ref(bv, av, o);
        if (!crc_good) crc = crc ^ ((ndata == 8 && gap == 0) ? 4'h1 : 4'($urandom_range(1, 15)));
        for (int k = 0; k < ndata; k++) begin
            if (k < 8) byt = ba[63 - 8*k -: 8];
            else       byt = 8'($urandom);
            applyStimulus(1'b0, byt, k != bad_stop);
            if (k == bad_stop) return;
            if (gap > 0) idle($urandom_range(0, gap));
        end
        applyStimulus(1'b1, {1'($urandom_range(0, 1)), o, crc}, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1; sin0 = 1'b1; sin1 = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        clear_model();
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int kind, nd;
        logic [31:0] ra, rb;
        rst = 1'b1; sin0 = 1'b1; sin1 = 1'b1;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checking = 1'b1;
        @(negedge clk); #1;
        checkOutput("reset.a", a0, 32'h0);
        checkOutput("reset.pkt_valid", pv1, 1'b0);
        checkOutput("reset.err_code", ec0, 2'b00);
        @(posedge clk); #1;

        checkOutput("model.crc", crc_ref(32'h2, 32'h3, 3'd0), 4'hA);

        act = 0;
        send_packet(32'h2, 32'h3, 3'd0, 1'b1, 8, -1, 0);
        idle(3);
        checkOutput("t1.a", a0, 32'h3);
        checkOutput("t1.b", b0, 32'h2);
        checkOutput("t1.op", op0, 3'd0);

        send_packet(32'h2, 32'h3, 3'd0, 1'b0, 8, -1, 0);
        idle(3);
        checkOutput("t2.err_code", ec0, 2'b10);
        checkOutput("t2.a", a0, 32'h3);

        send_packet(32'h2, 32'h3, 3'd0, 1'b1, 7, -1, 0);
        send_packet(32'h12345678, 32'h9ABCDEF0, 3'd6, 1'b1, 8, -1, 0);
        idle(3);
        checkOutput("t3.a", a0, 32'h9ABCDEF0);
        checkOutput("t3.op", op0, 3'd6);

        send_packet(32'hCAFE0001, 32'h0BADF00D, 3'd3, 1'b1, 8, 2, 0);
        idle(2);
        checkOutput("t4.err_code", ec0, 2'b01);
        send_packet(32'hCAFE0001, 32'h0BADF00D, 3'd3, 1'b1, 8, -1, 0);
        idle(3);
        checkOutput("t4.b", b0, 32'hCAFE0001);

        act = 1;
        idle(5);
        drive(1'b0);
        @(posedge clk); #1;
        idle(12);
        send_packet(32'h2, 32'h3, 3'd0, 1'b1, 8, -1, 0);
        idle(6);
        checkOutput("t5.a", a1, 32'h3);
        checkOutput("t5.b", b1, 32'h2);

        act = 0;
        for (int k = 0; k < 4; k++) applyStimulus(1'b0, 8'($urandom), 1'b1);
        drive(1'b0);
        repeat (5) begin @(posedge clk); #1; end
        do_reset();
        @(negedge clk); #1;
        checkOutput("t6.a", a0, 32'h0);
        checkOutput("t6.b1", b1, 32'h0);
        checkOutput("t6.err_code", ec0, 2'b00);
        @(posedge clk); #1;
        idle(4);
        send_packet(32'h01020304, 32'h05060708, 3'd7, 1'b1, 8, -1, 0);
        idle(3);
        checkOutput("t6.after", a0, 32'h05060708);

        for (int ph = 0; ph < 2; ph++) begin
            act = ph;
            idle(8);
            for (int p = 0; p < ((ph == 0) ? 40 : 15); p++) begin
                ra = $urandom; rb = $urandom;
                kind = $urandom_range(0, 9);
                case (kind)
                    6: send_packet(rb, ra, 3'($urandom), 1'b0, 8, -1, 3);
                    7: begin
                        nd = $urandom_range(0, 7);
                        send_packet(rb, ra, 3'($urandom), 1'b1, nd, -1, 3);
                    end
                    8: send_packet(rb, ra, 3'($urandom), 1'b1, 9, -1, 3);
                    9: begin
                        if (ph == 0) send_packet(rb, ra, 3'($urandom), 1'b1, 8, $urandom_range(0, 7), 3);
                        else         send_packet(rb, ra, 3'($urandom), 1'b1, 8, -1, 3);
                    end
                    default: send_packet(rb, ra, 3'($urandom), 1'b1, 8, -1, 3);
                endcase
                idle($urandom_range(0, 4));
            end
            idle(60);
        end

        checkOutput("events.drained", 64'(evq.size()), 64'd0);
        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
